// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and the bit-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_LO  = 7;
    localparam int unsigned SAMPLE_HI  = 9;
    localparam int unsigned DATA_BITS  = 8;

    // Two-out-of-three vote used to decide each bit value.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks, realignable by clr.
module uart_baud_tick #(
    parameter int unsigned DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(DIV);

    if (DIV < 4) begin : g_div_check
        $error("uart_baud_tick: DIV must be at least 4");
    end

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    // Free-running divider; clr restarts the phase from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a one-deep output buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic                 FPGA_CLK,
    input  logic                 FPGA_RST,
    input  logic                 UART_RXD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic                 rxd_meta_q;
    logic                 rxd_s;
    logic [1:0]           sync_fill_q;
    logic                 rxd_prev_q;

    state_t               state_q, state_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [OS_W-1:0]      os;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;

    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_d;
    logic                 frame_err_d;
    logic                 overrun_d;

    logic                 tick;
    logic                 tick_clr;
    logic                 decide;
    logic                 bit_val;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (FPGA_CLK),
        .rst  (FPGA_RST),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Two-flop synchronizer; sync_fill gates rxd_prev so the reset value of the
    // synchronizer is never mistaken for a line that has genuinely been seen high.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            rxd_meta_q  <= 1'b1;
            rxd_s       <= 1'b1;
            sync_fill_q <= 2'b00;
            rxd_prev_q  <= 1'b0;
        end else begin
            rxd_meta_q  <= UART_RXD;
            rxd_s       <= rxd_meta_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            rxd_prev_q  <= rxd_s & sync_fill_q[1];
        end
    end

    // os_q holds ticks already elapsed in the bit; os numbers the tick now arriving.
    assign os      = os_q + OS_W'(1);
    assign decide  = tick && (os == OS_W'(SAMPLE_HI));
    assign bit_val = majority3(samp_q[1], samp_q[0], rxd_s);
    assign busy    = (state_q != IDLE);

    // Next-state, sampling and output-buffer logic.
    always_comb begin
        state_d     = state_q;
        os_d        = os_q;
        bit_d       = bit_q;
        samp_d      = samp_q;
        shreg_d     = shreg_q;
        tick_clr    = 1'b0;
        rx_data_d   = rx_data;
        rx_valid_d  = rx_valid;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (rx_valid && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (tick) begin
            os_d = os;
            if (os == OS_W'(SAMPLE_LO) || os == OS_W'(SAMPLE_HI - 1)) begin
                samp_d = {samp_q[0], rxd_s};
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!rxd_s && rxd_prev_q) begin
                    tick_clr = 1'b1;
                    os_d     = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (decide) begin
                    if (!bit_val) begin
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        state_d = IDLE;
                        // A same-cycle transfer frees the buffer for the new byte.
                        if (!rx_valid || rx_ready) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            state_q   <= IDLE;
            os_q      <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shreg_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shreg_q   <= shreg_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

endmodule
